// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART transmit-side control blocks.
// State encodings, byte width and default start timeout.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } txState_t;

    localparam int BYTE_W = 8;
    localparam int DEF_START_TIMEOUT = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around to bit 0.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] g
);

    // Scan downward so the candidate closest to ptr overwrites the rest.
    always_comb begin
        int k;
        logic [PTR_W-1:0] idx;
        valid = 1'b0;
        g = '0;
        k = 0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            idx = PTR_W'(k);
            if (req[idx]) begin
                valid = 1'b1;
                g = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers,
// with edge-triggered send sequencing and a start timeout.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int CNT_W = 5
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [N_REQ-1:0]        iREQ,
    input  logic [BYTE_W*N_REQ-1:0] iDATA,
    output logic [N_REQ-1:0]        oACK,
    output logic [N_REQ-1:0]        oGRANT,
    output logic                    oERR,
    output logic                    oIDLE,
    output logic                    oUT,
    output logic [BYTE_W-1:0]       oUTDATA,
    input  logic                    iUT
);

    localparam int PTR_W = $clog2(N_REQ);

    txState_t          state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [PTR_W-1:0]  ptr, ptrNext;
    logic [PTR_W-1:0]  owner, ownerNext, ownerInc;
    logic [PTR_W-1:0]  pickG;
    logic              pickValid;
    logic [BYTE_W-1:0] pickData, dataNext;
    logic [N_REQ-1:0]  grantNext, ackNext;
    logic              utNext, errNext, timeout;

    uart_rr_pick #(
        .N_REQ(N_REQ),
        .PTR_W(PTR_W)
    ) uPick (
        .req  (iREQ),
        .ptr  (ptr),
        .valid(pickValid),
        .g    (pickG)
    );

    always_comb begin
        pickData = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pickG == PTR_W'(k)) begin
                pickData = iDATA[k*BYTE_W +: BYTE_W];
            end
        end
    end

    assign ownerInc = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign timeout  = (cnt == CNT_W'(START_TIMEOUT - 1));

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            owner   <= '0;
            oGRANT  <= '0;
            oUTDATA <= '0;
            oUT     <= 1'b0;
            oACK    <= '0;
            oERR    <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            ptr     <= ptrNext;
            owner   <= ownerNext;
            oGRANT  <= grantNext;
            oUTDATA <= dataNext;
            oUT     <= utNext;
            oACK    <= ackNext;
            oERR    <= errNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        ptrNext   = ptr;
        ownerNext = owner;
        grantNext = oGRANT;
        dataNext  = oUTDATA;
        utNext    = oUT;
        ackNext   = '0;
        errNext   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pickValid && iUT) begin
                    stateNext = START;
                    ownerNext = pickG;
                    grantNext = '0;
                    grantNext[pickG] = 1'b1;
                    dataNext  = pickData;
                    utNext    = 1'b1;
                    cntNext   = '0;
                end
            end
            START: begin
                cntNext = cnt + 1'b1;
                // A falling iUT wins over a simultaneous timeout.
                if (!iUT) begin
                    utNext  = 1'b0;
                    ackNext[owner] = 1'b1;
                    ptrNext = ownerInc;
                    stateNext = SEND;
                end else if (timeout) begin
                    utNext    = 1'b0;
                    errNext   = 1'b1;
                    grantNext = '0;
                    ptrNext   = ownerInc;
                    stateNext = IDLE;
                end
            end
            SEND: begin
                utNext = 1'b0;
                if (iUT) begin
                    grantNext = '0;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                utNext    = 1'b0;
                grantNext = '0;
            end
        endcase
    end

    always_comb begin
        oIDLE = (state == IDLE);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART with a 3-stage input
// synchronizer, transaction-level arbiter model and directed scenarios.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int TO = 16;
    localparam int FRAME = 80;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [3:0]  iREQ;
    logic [31:0] iDATA;
    logic [3:0]  oACK, oGRANT;
    logic        oERR, oIDLE, oUT;
    logic [7:0]  oUTDATA;
    logic        iUT;

    uart_tx_arbiter #(
        .N_REQ(N),
        .START_TIMEOUT(TO),
        .CNT_W(5)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iREQ   (iREQ),
        .iDATA  (iDATA),
        .oACK   (oACK),
        .oGRANT (oGRANT),
        .oERR   (oERR),
        .oIDLE  (oIDLE),
        .oUT    (oUT),
        .oUTDATA(oUTDATA),
        .iUT    (iUT)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    int         ackLog[$];
    int         grantLog[$];
    logic [7:0] rxLog[$];
    logic [7:0] rxAll[$];
    logic [7:0] expBytes[$];
    int         errCnt = 0;

    int reqMode = 0;
    int uartMode = 0;
    logic [2:0] sync = '0;
    int busy = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int idxOf(logic [3:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int pick(logic [3:0] r, int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Behavioural model: who owns the UART, whether it has taken the byte,
    // how long oUT has been high, and the round-robin pointer.
    int         mOwner = -1;
    int         mPtr = 0;
    int         mHigh = 0;
    bit         mAcc = 0;
    logic [3:0] expGnt = '0, expAck = '0;
    logic       expUt = 0, expErr = 0;
    logic [7:0] expData = '0;
    bit         havePrev = 0;
    logic       pRst, pUt;
    logic [3:0] pReq;
    logic [31:0] pData;
    logic [3:0] prevGnt = '0;

    always @(negedge iCLK) begin
        if (havePrev) begin
            expAck = '0;
            expErr = 1'b0;
            if (!pRst) begin
                mOwner = -1;
                mPtr = 0;
                expGnt = '0;
                expUt = 1'b0;
                expData = '0;
            end else if (mOwner < 0) begin
                if (pReq != 0 && pUt) begin
                    mOwner = pick(pReq, mPtr);
                    mAcc = 0;
                    mHigh = 1;
                    expGnt = 4'(1 << mOwner);
                    expData = pData[8*mOwner +: 8];
                    expUt = 1'b1;
                end
            end else if (!mAcc) begin
                if (!pUt) begin
                    expUt = 1'b0;
                    expAck = 4'(1 << mOwner);
                    mAcc = 1;
                    mPtr = (mOwner + 1) % N;
                    expBytes.push_back(expData);
                end else if (mHigh == TO) begin
                    expUt = 1'b0;
                    expErr = 1'b1;
                    expGnt = '0;
                    mPtr = (mOwner + 1) % N;
                    mOwner = -1;
                end else begin
                    mHigh++;
                end
            end else if (pUt) begin
                expGnt = '0;
                mOwner = -1;
            end
            chk("grant", oGRANT, expGnt);
            chk("ut", oUT, expUt);
            chk("utdata", oUTDATA, expData);
            chk("ack", oACK, expAck);
            chk("err", oERR, expErr);
            chk("idle", oIDLE, mOwner < 0);
            if (oACK != 0) ackLog.push_back(idxOf(oACK));
            if (oERR) errCnt++;
            if (oGRANT != 0 && prevGnt == 0) grantLog.push_back(idxOf(oGRANT));
            prevGnt = oGRANT;
        end
        pRst = iRST_N;
        pUt = iUT;
        pReq = iREQ;
        pData = iDATA;
        havePrev = 1;
    end

    task automatic step();
        logic prevS;
        @(posedge iCLK);
        #1;
        for (int k = 0; k < N; k++) begin
            if (iREQ[k] && oACK[k]) begin
                if (reqMode == 0) begin
                    iREQ[k] = 1'b0;
                end else if (reqMode == 2) begin
                    if ($urandom_range(1, 0) == 0) iREQ[k] = 1'b0;
                    else iDATA[8*k +: 8] = 8'($urandom);
                end
            end else if (reqMode == 2) begin
                if (!iREQ[k] && $urandom_range(9, 0) < 2) begin
                    iREQ[k] = 1'b1;
                    iDATA[8*k +: 8] = 8'($urandom);
                end else if (iREQ[k] && $urandom_range(49, 0) == 0) begin
                    iREQ[k] = 1'b0;
                end
            end
        end
        prevS = sync[2];
        sync = {sync[1:0], oUT};
        case (uartMode)
            1: iUT = 1'b1;
            2: iUT = 1'b0;
            default: begin
                if (busy > 0) begin
                    busy--;
                    iUT = (busy == 0);
                end else if (sync[2] && !prevS) begin
                    rxLog.push_back(oUTDATA);
                    rxAll.push_back(oUTDATA);
                    busy = FRAME;
                    iUT = 1'b0;
                end else begin
                    iUT = 1'b1;
                end
            end
        endcase
    endtask

    task automatic clearLogs();
        ackLog.delete();
        grantLog.delete();
        rxLog.delete();
        errCnt = 0;
    endtask

    task automatic waitAck(int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (oACK == 0 && n < budget);
        chk("wait_ack", oACK != 0, 1);
    endtask

    task automatic waitFree(int budget);
        int n;
        n = 0;
        while (!(oIDLE && iUT) && n < budget) begin
            step();
            n++;
        end
        chk("wait_free", oIDLE && iUT, 1);
    endtask

    task automatic pulseReset();
        iRST_N = 1'b0;
        step();
        iRST_N = 1'b1;
    endtask

    initial begin
        int n, acks, hi;
        logic [7:0] b4 [4];
        iRST_N = 1'b0;
        iREQ = '0;
        iDATA = '0;
        iUT = 1'b1;
        repeat (3) step();
        iRST_N = 1'b1;
        step();
        chk("rst_idle", oIDLE, 1);
        chk("rst_grant", oGRANT, 0);
        chk("rst_ut", oUT, 0);
        chk("rst_data", oUTDATA, 0);

        clearLogs();
        iDATA[23:16] = 8'hA5;
        iREQ = 4'b0100;
        step();
        chk("single_grant", oGRANT, 4'b0100);
        waitAck(40);
        chk("single_ack", oACK, 4'b0100);
        waitFree(200);
        chk("single_nack", ackLog.size(), 1);
        chk("single_nrx", rxLog.size(), 1);
        if (rxLog.size() > 0) chk("single_rx", rxLog[0], 8'hA5);
        chk("single_idle", oIDLE, 1);

        clearLogs();
        iDATA[7:0] = 8'h11;
        iDATA[15:8] = 8'h22;
        iREQ = 4'b0011;
        waitAck(40);
        waitFree(200);
        waitAck(40);
        waitFree(200);
        chk("wrap_ngrant", grantLog.size(), 2);
        if (grantLog.size() > 1) begin
            chk("wrap_g0", grantLog[0], 0);
            chk("wrap_g1", grantLog[1], 1);
        end
        chk("wrap_nrx", rxLog.size(), 2);
        if (rxLog.size() > 1) chk("wrap_rx1", rxLog[1], 8'h22);

        pulseReset();
        clearLogs();
        reqMode = 1;
        iDATA = 32'h43322110;
        b4 = '{8'h10, 8'h21, 8'h32, 8'h43};
        iREQ = 4'hF;
        n = 0;
        acks = 0;
        while (acks < 5 && n < 600) begin
            step();
            n++;
            if (oACK != 0) acks++;
        end
        iREQ = '0;
        reqMode = 0;
        chk("all4_acks", acks, 5);
        waitFree(200);
        chk("all4_nack", ackLog.size(), 5);
        for (int i = 0; i < 5 && i < ackLog.size(); i++) chk("all4_order", ackLog[i], i % 4);
        for (int i = 0; i < 5 && i < rxLog.size(); i++) chk("all4_rx", rxLog[i], b4[i % 4]);

        clearLogs();
        uartMode = 1;
        iDATA[7:0] = 8'h77;
        iREQ = 4'b0001;
        n = 0;
        while (!oUT && n < 20) begin
            step();
            n++;
        end
        hi = 0;
        while (oUT && hi < 40) begin
            hi++;
            step();
        end
        chk("to_high", hi, TO);
        chk("to_err", oERR, 1);
        chk("to_grant", oGRANT, 0);
        chk("to_ack", oACK, 0);
        iREQ = '0;
        step();
        step();
        chk("to_errcnt", errCnt, 1);
        chk("to_noack", ackLog.size(), 0);
        uartMode = 0;

        clearLogs();
        uartMode = 2;
        iUT = 1'b0;
        iDATA[7:0] = 8'h3C;
        iREQ = 4'b0001;
        repeat (10) step();
        chk("busy_nogrant", oGRANT, 0);
        uartMode = 0;
        iUT = 1'b1;
        step();
        chk("busy_grant", oGRANT, 4'b0001);
        waitAck(40);
        waitFree(200);
        if (rxLog.size() > 0) chk("busy_rx", rxLog[0], 8'h3C);

        clearLogs();
        iDATA[15:8] = 8'h5C;
        iREQ = 4'b0010;
        waitAck(40);
        repeat (5) step();
        iRST_N = 1'b0;
        step();
        chk("mrst_ut", oUT, 0);
        chk("mrst_grant", oGRANT, 0);
        chk("mrst_ack", oACK, 0);
        chk("mrst_idle", oIDLE, 1);
        chk("mrst_data", oUTDATA, 0);
        iRST_N = 1'b1;
        repeat (5) step();
        chk("mrst_noack", ackLog.size(), 1);
        iDATA[31:24] = 8'hC3;
        iREQ = 4'b1000;
        waitAck(200);
        chk("mrst_newack", oACK, 4'b1000);
        waitFree(200);
        if (rxLog.size() > 0) chk("mrst_rx", rxLog[rxLog.size()-1], 8'hC3);

        pulseReset();
        reqMode = 2;
        repeat (3000) step();
        reqMode = 0;
        iREQ = '0;
        waitFree(300);

        chk("sb_len", rxAll.size(), expBytes.size());
        for (int i = 0; i < rxAll.size() && i < expBytes.size(); i++)
            chk("sb_byte", rxAll[i], expBytes[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
